// File: rtl/seq_sdiv_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_sdiv_pkg;

   localparam int SDIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } sdiv_state_e;

endpackage

// File: rtl/sdiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract, keep or restore, and shift the new quotient bit in.
module sdiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic             qbit;

   assign shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
   assign trial   = {1'b0, shifted} - {2'b00, dvs};
   // A set top bit of rem_in means the shifted value already exceeds any divisor.
   assign qbit    = rem_in[WIDTH] | ~trial[WIDTH+1];
   assign rem_out = qbit ? trial[WIDTH:0] : shifted;
   assign quo_out = {quo_in[WIDTH-2:0], qbit};

endmodule

// File: rtl/seq_sdiv.sv
// Sequential signed divider: magnitudes in IDLE, WIDTH restoring steps in
// CALC, sign fix-up in SIGN, one-cycle done pulse in DONE.
module seq_sdiv
   import seq_sdiv_pkg::*;
#(
   parameter int WIDTH = SDIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sdiv_state_e      state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   prem;
   logic             q_neg, r_neg, dz;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] abs_dvd, abs_dvs, rem_mag;

   // Most-negative operand negates to itself, which is its correct unsigned magnitude.
   assign abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
   assign abs_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
   assign rem_mag = prem[WIDTH-1:0];

   sdiv_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (prem),
      .quo_in  (quo_sh),
      .dvs     (dvs),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = CALC;
         CALC: if (cnt == LAST) state_nxt = SIGN;
         SIGN: state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         quo_sh    <= '0;
         dvs       <= '0;
         prem      <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         dz        <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               quo_sh <= abs_dvd;
               dvs    <= abs_dvs;
               prem   <= '0;
               cnt    <= '0;
               q_neg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
               r_neg  <= dividend[WIDTH-1];
               dz     <= (divisor == '0);
            end
            CALC: begin
               prem   <= step_rem;
               quo_sh <= step_quo;
               cnt    <= cnt + CW'(1);
            end
            SIGN: begin
               // Zero divisor: remainder re-signs back to the original dividend.
               quotient  <= dz ? '1 : (q_neg ? -quo_sh : quo_sh);
               remainder <= r_neg ? -rem_mag : rem_mag;
               div_zero  <= dz;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_sdiv.sv
// Directed and random checks of seq_sdiv against a plain-arithmetic model.
module tb_seq_sdiv;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0, divisor = '0;
   logic        busy, done, div_zero;
   logic [31:0] quotient, remainder;

   int n_vec = 0;
   int n_miss = 0;

   seq_sdiv #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
      .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
      .remainder(remainder), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: truncating signed division, with the zero-divisor and overflow rules.
   function automatic void ref_div(input int a, input int b, output logic [31:0] q,
                                   output logic [31:0] r, output logic dz);
      dz = (b == 0);
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (a == 32'sh8000_0000 && b == -1) begin
         q = 32'h8000_0000;
         r = 0;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Called just after the sampling edge; returns in the DONE cycle.
   task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      logic        dz;
      int          k;
      bit          got;
      k = 0;
      got = 0;
      ref_div(a, b, q, r, dz);
      while (k < 60 && !got) begin
         @(negedge clk);
         k++;
         if (k == 1) chk({tag, "_busy"}, busy, 1);
         if (done) got = 1;
      end
      chk({tag, "_lat"}, k, 34);
      chk({tag, "_q"}, quotient, q);
      chk({tag, "_r"}, remainder, r);
      chk({tag, "_dz"}, div_zero, dz);
   endtask

   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q_hold;
      launch(a, b);
      wait_done(tag, a, b);
      q_hold = quotient;
      @(negedge clk);
      chk({tag, "_pulse"}, done, 0);
      chk({tag, "_hold"}, quotient, q_hold);
   endtask

   initial begin
      logic [31:0] a, b;
      int pulses, lat;
      logic [31:0] cq, cr;

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dz", div_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      op("c1", 32'd100, 32'd7);
      op("c2a", -32'sd100, 32'd7);
      op("c2b", 32'd100, -32'sd7);
      op("c3a", 32'h8000_0000, 32'hFFFF_FFFF);
      op("c3b", 32'h8000_0000, 32'd2);
      op("c4a", 32'd55, 32'd0);
      op("c4b", 32'd9, 32'd3);
      op("negzero", -32'sd55, 32'd0);
      op("minzero", 32'h8000_0000, 32'd0);
      op("minmin", 32'h8000_0000, 32'h8000_0000);
      op("maxneg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF);

      // Start during DONE is ignored, start in the next IDLE cycle is taken.
      launch(32'd100, 32'd7);
      wait_done("bb0", 32'd100, 32'd7);
      dividend = -32'sd77;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("done_start_ignored", busy, 0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("bb1", -32'sd77, 32'd5);
      @(negedge clk);

      // Second start mid-operation must not disturb the first.
      launch(32'd1000, 32'd7);
      pulses = 0;
      lat = 0;
      cq = '0;
      cr = '0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 10) begin
            dividend = 32'd5;
            divisor  = 32'd1;
            start    = 1'b1;
         end
         if (k == 11) start = 1'b0;
         if (done) begin
            pulses++;
            lat = k;
            cq = quotient;
            cr = remainder;
         end
      end
      chk("c5_pulses", pulses, 1);
      chk("c5_lat", lat, 34);
      chk("c5_q", cq, 32'd142);
      chk("c5_r", cr, 32'd6);

      // Reset mid-operation aborts with no done.
      launch(32'd12345, -32'sd17);
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("c6_busy", busy, 0);
      chk("c6_done", done, 0);
      chk("c6_q", quotient, 0);
      chk("c6_r", remainder, 0);
      chk("c6_dz", div_zero, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("c6_nodone", pulses, 0);
      op("c6_after", 32'd21, 32'd4);

      for (int i = 0; i < 50; i++) begin
         a = $urandom;
         case (i % 5)
            0: b = $urandom;
            1: b = 32'($urandom_range(0, 20)) - 32'd10;
            2: b = $urandom >> $urandom_range(0, 31);
            3: begin a = a >> $urandom_range(0, 31); b = -($urandom & 32'hFF); end
            default: b = 32'($urandom_range(1, 3));
         endcase
         op("rnd", a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seq_sdiv.md
SEQ_SDIV -- requirements
Module: seq_sdiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: signed two's-complement, sampled with start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: signed two's-complement, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: signed result, truncated toward zero.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: signed result; its sign follows the dividend.
REQ-011 The block SHALL have port div_zero, output, 1 bit: set with done when the divisor was 0.

Function
REQ-012 The block SHALL be an FSM with states IDLE, CALC, SIGN and DONE.
REQ-013 IDLE SHALL latch |dividend| and |divisor| (by two's-complement negate when the MSB is 1), the result sign (dividend MSB XOR divisor MSB), the remainder sign (dividend MSB) and the zero-divisor flag on start=1, then go to CALC.
REQ-014 CALC SHALL perform restoring division one quotient bit per cycle, MSB first, for exactly WIDTH cycles, using a WIDTH+1-bit partial remainder and a log2(WIDTH)+1-bit iteration counter.
REQ-015 SIGN SHALL negate the quotient when the result sign is 1 and negate the remainder when the remainder sign is 1, in one cycle.
REQ-016 DONE SHALL assert done for exactly one cycle and SHALL return to IDLE.
REQ-017 The done pulse SHALL appear exactly WIDTH+2 cycles after the edge that samples start (34 cycles for WIDTH=32).
REQ-018 quotient, remainder and div_zero SHALL hold their values from the done pulse until the next done pulse.
REQ-019 start SHALL be ignored while busy; an operation in flight SHALL NOT be disturbed.
REQ-020 A start asserted in the DONE cycle SHALL be ignored; a start asserted in the following IDLE cycle SHALL be accepted.
REQ-021 Divisor 0 SHALL keep normal latency and SHALL produce quotient all-ones, remainder = dividend unmodified, and div_zero=1.
REQ-022 The most-negative dividend divided by -1 SHALL wrap to quotient = most-negative value and remainder 0, with div_zero=0.
REQ-023 The most-negative value SHALL be handled as operand magnitude 2^(WIDTH-1) as an unsigned value, without loss.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0 and clear all internal registers.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave normally.

Structure
REQ-026 A shared package SHALL hold the state typedef (IDLE, CALC, SIGN, DONE) and the default width constant 32.
REQ-027 The single-cycle restoring step (shift, trial subtract, conditional restore, quotient bit) SHALL be a sub-module named sdiv_step.
REQ-028 The negate/abs logic SHALL be inline.

Verification
REQ-029 Case 1: 100 / 7 -> quotient 14, remainder 2, div_zero 0; done exactly 34 cycles after start.
REQ-030 Case 2: -100 / 7 -> quotient -14, remainder -2; and 100 / -7 -> quotient -14, remainder 2.
REQ-031 Case 3: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; and 0x80000000 / 2 -> quotient 0xC0000000, remainder 0.
REQ-032 Case 4: 55 / 0 -> quotient 0xFFFFFFFF, remainder 55, div_zero 1; then 9 / 3 -> quotient 3, div_zero 0.
REQ-033 Case 5: a second start pulsed 10 cycles into an operation -> ignored, first result correct, only one done pulse.
REQ-034 Case 6: rst_n driven low at cycle 15 of an operation -> all outputs 0 immediately, no done; a following 21 / 4 -> quotient 5, remainder 1.
